// File: rtl/stack_spill_fill_pkg.sv
// Shared encodings for the stack spill/fill sequencer and its Io request
// interface: RAM access direction and destination register codes.
package stack_spill_fill_pkg;

    // Io request direction
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    // Io destination register codes for the top-of-stack registers
    localparam logic [2:0] REG_S1 = 3'd1;
    localparam logic [2:0] REG_S2 = 3'd2;
    localparam logic [2:0] REG_S3 = 3'd3;

    // Destination register tag for stack element idx (0 -> S1 ... 2 -> S3)
    function automatic logic [2:0] dest_reg(input logic [1:0] idx);
        logic [2:0] code;
        case (idx)
            2'd0:    code = REG_S1;
            2'd1:    code = REG_S2;
            default: code = REG_S3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/stack_spill_fill.sv
// Stack spill/fill sequencer: moves up to three top-of-stack words between the
// core and RAM as a back-to-back burst of single-word requests to Io.
// Spill writes S1..Sn to sp+0..sp+n-1, fill reads sp+0..sp+n-1 into S1..Sn.
module stack_spill_fill
    import stack_spill_fill_pkg::*;
#(
    parameter int addrBits = 8,
    parameter int dataBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [1:0]          count,
    input  logic [addrBits-1:0] stackPointer,
    input  logic [dataBits-1:0] topOfStack1,
    input  logic [dataBits-1:0] topOfStack2,
    input  logic [dataBits-1:0] topOfStack3,
    output logic                ioReq,
    output logic                ioReadWriteAction,
    output logic [addrBits-1:0] ioAddress,
    output logic [dataBits-1:0] ioWriteValue,
    output logic [2:0]          ioDestinationRegister,
    input  logic                ioDone,
    input  logic [dataBits-1:0] ioReadValue,
    output logic [dataBits-1:0] nextTopOfStack1,
    output logic [dataBits-1:0] nextTopOfStack2,
    output logic [dataBits-1:0] nextTopOfStack3,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Operation context captured on start
    logic [1:0]          state_q, state_d;
    logic [addrBits-1:0] sp_q, sp_d;
    logic                mode_q, mode_d;
    logic [1:0]          count_q, count_d;
    logic [dataBits-1:0] tos1_q, tos1_d;
    logic [dataBits-1:0] tos2_q, tos2_d;
    logic [dataBits-1:0] tos3_q, tos3_d;
    logic [1:0]          k_q, k_d;

    // Registered outputs
    logic                req_q, req_d;
    logic                rw_q, rw_d;
    logic [addrBits-1:0] addr_q, addr_d;
    logic [dataBits-1:0] wdata_q, wdata_d;
    logic [2:0]          dest_q, dest_d;
    logic [dataBits-1:0] nts1_q, nts1_d;
    logic [dataBits-1:0] nts2_q, nts2_d;
    logic [dataBits-1:0] nts3_q, nts3_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [1:0]          k_next_s;

    // Captured stack value for element idx
    function automatic logic [dataBits-1:0] pick_tos(input logic [1:0] idx,
                                                     input logic [dataBits-1:0] t1,
                                                     input logic [dataBits-1:0] t2,
                                                     input logic [dataBits-1:0] t3);
        logic [dataBits-1:0] v;
        case (idx)
            2'd0:    v = t1;
            2'd1:    v = t2;
            default: v = t3;
        endcase
        return v;
    endfunction

    assign k_next_s = k_q + 2'd1;

    // Next-state logic: capture on start, advance the element on each completed request
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        mode_d  = mode_q;
        count_d = count_q;
        tos1_d  = tos1_q;
        tos2_d  = tos2_q;
        tos3_d  = tos3_q;
        k_d     = k_q;
        req_d   = req_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dest_d  = dest_q;
        nts1_d  = nts1_q;
        nts2_d  = nts2_q;
        nts3_d  = nts3_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sp_d    = stackPointer;
                    mode_d  = mode;
                    count_d = count;
                    tos1_d  = topOfStack1;
                    tos2_d  = topOfStack2;
                    tos3_d  = topOfStack3;
                    nts1_d  = topOfStack1;
                    nts2_d  = topOfStack2;
                    nts3_d  = topOfStack3;
                    k_d     = 2'd0;
                    if (count == 2'd0) begin
                        // Nothing to move: complete immediately without a request
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        req_d   = 1'b0;
                    end else begin
                        state_d = ST_XFER;
                        busy_d  = 1'b1;
                        req_d   = 1'b1;
                        addr_d  = stackPointer;
                        dest_d  = REG_S1;
                        rw_d    = mode ? RAM_READ : RAM_WRITE;
                        wdata_d = mode ? {dataBits{1'b0}} : topOfStack1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_XFER: begin
                if (req_q && ioDone) begin
                    if (mode_q) begin
                        case (k_q)
                            2'd0:    nts1_d = ioReadValue;
                            2'd1:    nts2_d = ioReadValue;
                            default: nts3_d = ioReadValue;
                        endcase
                    end else begin
                        nts1_d = nts1_q;
                    end
                    if (k_next_s == count_q) begin
                        state_d = ST_FINISH;
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next element follows with no gap cycle; address wraps modulo 2^addrBits
                        k_d     = k_next_s;
                        addr_d  = sp_q + addrBits'(k_next_s);
                        dest_d  = dest_reg(k_next_s);
                        wdata_d = mode_q ? {dataBits{1'b0}}
                                         : pick_tos(k_next_s, tos1_q, tos2_q, tos3_q);
                    end
                end else begin
                    // Io wait state: payload held stable
                    state_d = ST_XFER;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sp_q    <= {addrBits{1'b0}};
            mode_q  <= 1'b0;
            count_q <= 2'd0;
            tos1_q  <= {dataBits{1'b0}};
            tos2_q  <= {dataBits{1'b0}};
            tos3_q  <= {dataBits{1'b0}};
            k_q     <= 2'd0;
            req_q   <= 1'b0;
            rw_q    <= RAM_READ;
            addr_q  <= {addrBits{1'b0}};
            wdata_q <= {dataBits{1'b0}};
            dest_q  <= REG_S1;
            nts1_q  <= {dataBits{1'b0}};
            nts2_q  <= {dataBits{1'b0}};
            nts3_q  <= {dataBits{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            tos1_q  <= tos1_d;
            tos2_q  <= tos2_d;
            tos3_q  <= tos3_d;
            k_q     <= k_d;
            req_q   <= req_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dest_q  <= dest_d;
            nts1_q  <= nts1_d;
            nts2_q  <= nts2_d;
            nts3_q  <= nts3_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ioReq                 = req_q;
    assign ioReadWriteAction     = rw_q;
    assign ioAddress             = addr_q;
    assign ioWriteValue          = wdata_q;
    assign ioDestinationRegister = dest_q;
    assign nextTopOfStack1       = nts1_q;
    assign nextTopOfStack2       = nts2_q;
    assign nextTopOfStack3       = nts3_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule
